// File: rtl/divider_scheduler_if.sv
// Request/response bundle between the application timers (master) and
// divider_scheduler (slave).
interface divider_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 28,
  parameter int PER_W   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] div_value;
  logic [NUM_REQ*PER_W-1:0] per_count;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     clock_out;
  logic                     tick_out;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req, div_value, per_count,
    input  grant, busy, clock_out, tick_out, done
  );

  modport slave (
    input  req, div_value, per_count,
    output grant, busy, clock_out, tick_out, done
  );
endinterface

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one programmable clock divider among NUM_REQ requesters.
// Optional owner-abort during RUN is enabled by defining DIVSCHED_ABORT_EN.

// Per-requester slice: ratio clamp plus grant/done decode for this lane.
module divider_scheduler_lane #(
  parameter int CNT_W = 28
) (
  input  logic [CNT_W-1:0] div_raw,
  input  logic             own,
  input  logic             active,
  input  logic             fin,
  output logic [CNT_W-1:0] div_clamp,
  output logic             grant_bit,
  output logic             done_bit
);
  assign div_clamp = (div_raw < CNT_W'(2)) ? CNT_W'(2) : div_raw;
  assign grant_bit = own & active;
  assign done_bit  = own & fin;
endmodule

module divider_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 28,
  parameter int PER_W   = 8
) (
  input  logic                clock_in,
  input  logic                reset_n,
  divider_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                         state, state_nxt;
  logic [PTR_W-1:0]               last_ptr, win_idx;
  logic                           win_found;
  logic [CNT_W-1:0]               div_r, cnt, half;
  logic [PER_W-1:0]               rem_r;
  logic [NUM_REQ-1:0][CNT_W-1:0]  div_a, div_cl;
  logic [NUM_REQ-1:0][PER_W-1:0]  per_a;
  logic [NUM_REQ-1:0]             grant_v, done_v;
  logic                           wrap, last_wrap, abort, run_ok;
  logic                           busy_c, active_c, fin_c;
  logic                           clock_out_q, tick_out_q;

  assign div_a = bus.div_value;
  assign per_a = bus.per_count;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    divider_scheduler_lane #(.CNT_W(CNT_W)) u_lane (
      .div_raw   (div_a[i]),
      .own       (last_ptr == PTR_W'(i)),
      .active    (active_c),
      .fin       (fin_c),
      .div_clamp (div_cl[i]),
      .grant_bit (grant_v[i]),
      .done_bit  (done_v[i])
    );
  end

  // Round-robin pick: first requesting lane after last_ptr, wrapping.
  always_comb begin : arb_p
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && bus.req[PTR_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
      end
    end
  end

  assign half      = div_r >> 1;
  assign wrap      = (cnt == div_r - CNT_W'(1));
  assign last_wrap = wrap && (rem_r == PER_W'(1));

`ifdef DIVSCHED_ABORT_EN
  assign abort = (state == S_RUN) && !bus.req[last_ptr];
`else
  assign abort = 1'b0;
`endif

  assign run_ok = (state == S_RUN) && !abort;

  // FSM: state register
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (win_found) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (per_a[last_ptr] == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_wrap) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_c   = (state != S_IDLE);
    active_c = (state != S_IDLE);
    fin_c    = (state == S_DONE);
  end

  // last_ptr is written on entry to LOAD so the lanes can present grant in LOAD itself.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      last_ptr <= PTR_W'(NUM_REQ-1);
      div_r    <= '0;
      rem_r    <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_found) last_ptr <= win_idx;
        S_LOAD: begin
          div_r <= div_cl[last_ptr];
          rem_r <= per_a[last_ptr];
          cnt   <= '0;
        end
        S_RUN: begin
          if (abort) begin
            cnt <= '0;
          end else if (wrap) begin
            cnt   <= '0;
            rem_r <= rem_r - PER_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // clock_out/tick_out are registered off cnt, hence one cycle behind it.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      clock_out_q <= 1'b0;
      tick_out_q  <= 1'b0;
    end else begin
      clock_out_q <= run_ok && (cnt < half);
      tick_out_q  <= run_ok && wrap;
    end
  end

  assign bus.grant     = grant_v;
  assign bus.done      = done_v;
  assign bus.busy      = busy_c;
  assign bus.clock_out = clock_out_q;
  assign bus.tick_out  = tick_out_q;
endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler: outputs sampled on falling edges,
// inputs changed on falling edges and picked up on the next rising edge.
module tb_divider_scheduler;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 28;
  localparam int PER_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  divider_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .PER_W(PER_W)) bus ();

  divider_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] o;
  assign o = {bus.grant, bus.busy, bus.clock_out, bus.tick_out, bus.done};

  // Packs {grant, busy, clock_out, tick_out, done}.
  function automatic logic [10:0] ev(input int g, input int b, input int c,
                                     input int t, input int d);
    return {4'(g), 1'(b), 1'(c), 1'(t), 4'(d)};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s: got grant=%b busy=%b clk=%b tick=%b done=%b, expected grant=%b busy=%b clk=%b tick=%b done=%b",
             tag, o[10:7], o[6], o[5], o[4], o[3:0],
             exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic cyc(input string tag, input logic [10:0] exp);
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic setjob(input int i, input int dv, input int pc);
    bus.div_value[i*CNT_W +: CNT_W] = CNT_W'(dv);
    bus.per_count[i*PER_W +: PER_W] = PER_W'(pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req = '0; bus.div_value = '0; bus.per_count = '0;
    repeat (2) @(negedge clk);
    cyc("reset_state", ev(0,0,0,0,0));
    rst_n = 1'b1;

    // ratio 4, 2 periods on requester 0
    setjob(0, 4, 2); bus.req = 4'b0001;
    @(negedge clk);
    cyc("t1_L",   ev(1,1,0,0,0));
    cyc("t1_L1",  ev(1,1,0,0,0));
    cyc("t1_L2",  ev(1,1,1,0,0));
    cyc("t1_L3",  ev(1,1,1,0,0));
    cyc("t1_L4",  ev(1,1,0,0,0));
    cyc("t1_L5",  ev(1,1,0,1,0));
    cyc("t1_L6",  ev(1,1,1,0,0));
    cyc("t1_L7",  ev(1,1,1,0,0));
    cyc("t1_L8",  ev(1,1,0,0,0));
    cyc("t1_L9",  ev(1,1,0,1,1));
    bus.req = '0;
    cyc("t1_L10", ev(0,0,0,0,0));

    // all four requesting, ratio 2, 1 period: 0,1,2,3,0
    rst_n = 1'b0; #1;
    chk("t2_rst", ev(0,0,0,0,0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) setjob(i, 2, 1);
    bus.req = 4'b1111;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      g = 1 << (j % 4);
      cyc("t2_load", ev(g,1,0,0,0));
      cyc("t2_run0", ev(g,1,0,0,0));
      cyc("t2_run1", ev(g,1,1,0,0));
      cyc("t2_done", ev(g,1,0,1,g));
      if (j == 4) bus.req = '0;
      cyc("t2_idle", ev(0,0,0,0,0));
    end

    // ratio 0 behaves as 2
    setjob(1, 0, 2); bus.req = 4'b0010;
    @(negedge clk);
    cyc("t3a_L",  ev(2,1,0,0,0));
    cyc("t3a_L1", ev(2,1,0,0,0));
    cyc("t3a_L2", ev(2,1,1,0,0));
    cyc("t3a_L3", ev(2,1,0,1,0));
    cyc("t3a_L4", ev(2,1,1,0,0));
    cyc("t3a_L5", ev(2,1,0,1,2));
    bus.req = '0;
    cyc("t3a_L6", ev(0,0,0,0,0));

    // ratio 1 behaves as 2
    setjob(2, 1, 1); bus.req = 4'b0100;
    @(negedge clk);
    cyc("t3b_L",  ev(4,1,0,0,0));
    cyc("t3b_L1", ev(4,1,0,0,0));
    cyc("t3b_L2", ev(4,1,1,0,0));
    cyc("t3b_L3", ev(4,1,0,1,4));
    bus.req = '0;
    cyc("t3b_L4", ev(0,0,0,0,0));

    // zero periods: LOAD then DONE, no tick
    setjob(3, 5, 0); bus.req = 4'b1000;
    @(negedge clk);
    cyc("t4_L",  ev(8,1,0,0,0));
    cyc("t4_L1", ev(8,1,0,0,8));
    bus.req = '0;
    cyc("t4_L2", ev(0,0,0,0,0));
    cyc("t4_L3", ev(0,0,0,0,0));

    // reset mid-RUN; afterwards the lowest active requester wins again
    setjob(1, 4, 3); setjob(2, 4, 3); bus.req = 4'b0110;
    @(negedge clk);
    cyc("t5_L",  ev(2,1,0,0,0));
    cyc("t5_L1", ev(2,1,0,0,0));
    cyc("t5_L2", ev(2,1,1,0,0));
    #2 rst_n = 1'b0;
    #1 chk("t5_async", ev(0,0,0,0,0));
    @(negedge clk);
    chk("t5_held", ev(0,0,0,0,0));
    rst_n = 1'b1;
    @(negedge clk);
    cyc("t5_regrant", ev(2,1,0,0,0));
    rst_n = 1'b0; bus.req = '0;
    @(negedge clk); rst_n = 1'b1;

    // owner 0 (ratio 8, 4 periods) drops req in its 4th RUN cycle; 1 pending
    setjob(0, 8, 4); setjob(1, 2, 1); bus.req = 4'b0011;
    @(negedge clk);
    cyc("t6_L",  ev(1,1,0,0,0));
    cyc("t6_L1", ev(1,1,0,0,0));
    cyc("t6_L2", ev(1,1,1,0,0));
    cyc("t6_L3", ev(1,1,1,0,0));
    chk("t6_L4", ev(1,1,1,0,0));
    bus.req = 4'b0010;
    @(negedge clk);
`ifdef DIVSCHED_ABORT_EN
    cyc("t6_abort_idle", ev(0,0,0,0,0));
    cyc("t6_next_load",  ev(2,1,0,0,0));
    cyc("t6_next_run0",  ev(2,1,0,0,0));
    cyc("t6_next_run1",  ev(2,1,1,0,0));
    cyc("t6_next_done",  ev(2,1,0,1,2));
    bus.req = '0;
    cyc("t6_end_idle",   ev(0,0,0,0,0));
`else
    cyc("t6_L5", ev(1,1,1,0,0));
    repeat (3) @(negedge clk);
    cyc("t6_tick1", ev(1,1,0,1,0));
    repeat (23) @(negedge clk);
    cyc("t6_done",      ev(1,1,0,1,1));
    cyc("t6_idle",      ev(0,0,0,0,0));
    cyc("t6_next_load", ev(2,1,0,0,0));
    cyc("t6_next_run0", ev(2,1,0,0,0));
    cyc("t6_next_run1", ev(2,1,1,0,0));
    cyc("t6_next_done", ev(2,1,0,1,2));
    bus.req = '0;
    cyc("t6_end_idle",  ev(0,0,0,0,0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/divider_scheduler.md
# divider_scheduler

Shares one programmable clock divider among `NUM_REQ` requesters.
- Each requester asks for a divide ratio and a number of output periods.
- The block grants requesters round-robin and runs the divider for the granted job.
- It drives a square-wave `clock_out` plus a one-cycle `tick_out` per period, then reports completion per requester.
- It sits between the application timers and the shared divider datapath, and replaces the fixed-ratio free-running divider wherever ratios must change at run time.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 28: width of the divide ratio and of the internal period counter.
- `PER_W`, 8: width of the requested period count.
- `clock_in`, in, 1: single system clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, `NUM_REQ`: level request per requester; held until `done` is seen.
- `div_value`, in, `NUM_REQ*CNT_W`: divide ratio; requester i at `[i*CNT_W +: CNT_W]`.
- `per_count`, in, `NUM_REQ*PER_W`: number of output periods; requester i at `[i*PER_W +: PER_W]`.
- `grant`, out, `NUM_REQ`: one-hot owner; high from LOAD through DONE.
- `busy`, out, 1: high in LOAD, RUN and DONE.
- `clock_out`, out, 1: divided square wave.
- `tick_out`, out, 1: one-cycle pulse per completed period.
- `done`, out, `NUM_REQ`: one-cycle completion pulse, bit i for requester i.

## Operation
States are IDLE, LOAD, RUN and DONE.
- **IDLE:** if any `req` bit is high, pick the first requester after `last_ptr` (wrapping), then go to LOAD.
- **LOAD** (one cycle):
  - Latch the winner's `div_value` into `div_r`, clamped to a minimum of 2 (0 and 1 become 2).
  - Latch the winner's `per_count` into `rem_r`.
  - Set `last_ptr` to the winner and assert `grant`.
  - If `rem_r` is 0, go to DONE; otherwise go to RUN with `cnt` = 0.
- **RUN:**
  - `cnt` increments each cycle.
  - When `cnt == div_r-1`: `cnt` returns to 0, `rem_r` decrements, and `tick_out` is set on the next cycle.
  - When that wrap occurs with `rem_r == 1`, go to DONE.
- **DONE** (one cycle): `done[owner]` is high, then go to IDLE with `grant` cleared.
- `clock_out` is registered. In RUN it is `(cnt < div_r/2)` (integer divide). It is 0 in every other state.
- Only the latched values are used. `div_value` and `per_count` changes after LOAD are ignored.
- Arbitration is evaluated only in IDLE. A request rising during RUN waits.
- `done` pulses only for the owner. A requester still holding `req` after `done` is eligible again, behind the others in round-robin order.
- Reset values:
  - `grant` = 0, `busy` = 0, `clock_out` = 0, `tick_out` = 0, `done` = 0.
  - State = IDLE, `cnt` = 0, `rem_r` = 0, `last_ptr` = `NUM_REQ-1`, so requester 0 wins first.
- Reset asserted mid-job clears everything immediately. No `done` is produced.

## Timing
Cycle L is the LOAD cycle; `req` is sampled high in IDLE at cycle L-1.
- `grant` and `busy` are high from L.
- `cnt` = 0 at L+1.
- The k-th `tick_out` pulse is at L+1+k*`div_r` (for ratio 4: L+5, L+9, ...). `tick_out` is never high in LOAD.
- DONE coincides with the last `tick_out` at L+1+N*`div_r`. `done` is high in that cycle.
- `grant` and `busy` drop at L+2+N*`div_r`.
- The earliest next LOAD is 2 cycles after DONE (IDLE then LOAD).
- With `per_count` = 0: DONE at L+1, no `tick_out`, `clock_out` stays 0.
- `clock_out` lags `cnt` by one cycle. With an odd `div_r` the high phase is `div_r/2` cycles (floor).

## Configuration
- `DIVSCHED_ABORT_EN` defined:
  - If the owner drops `req` while in RUN, the block goes to IDLE on the next cycle.
  - No `done` is produced; `grant`, `clock_out` and `tick_out` are cleared and `cnt` is reset to 0.
  - `last_ptr` keeps the aborted requester.
- `DIVSCHED_ABORT_EN` undefined: `req` is ignored after LOAD and the job always runs to DONE.

## Test plan
- Reset release, then `req` = 0001, ratio 4, 2 periods:
  - `grant` = 0001 from L.
  - `tick_out` at L+5 and L+9; `done[0]` at L+9.
  - `clock_out` high 2 cycles and low 2 cycles per period.
  - `busy` low at L+10.
- `req` = 1111 held, each job 1 period of ratio 2: grants go 0,1,2,3,0 in that order, each job spans 5 cycles.
- Ratio 0 and ratio 1 requests: both behave as ratio 2, with a tick every 2 cycles.
- `per_count` = 0: `done` at L+1, no `tick_out`, `busy` high for exactly 2 cycles.
- `reset_n` pulsed low mid-RUN: all outputs are 0 asynchronously. After release the first grant goes to the lowest active requester.
- With `DIVSCHED_ABORT_EN`: owner drops `req` after 3 RUN cycles, ratio 8, 4 periods.
  - IDLE follows on the next cycle, with no `done`.
  - A pending requester is granted 1 cycle later.
  - Without the macro the same stimulus completes all 4 periods.
